// File: rtl/axi_mst_arbiter.sv
// Round-robin arbiter merging NUM_MST internal request ports onto one AXI3 master port.
// Define AXI_ARB_WRITE_EN to build the write path; otherwise the block is read-only.
module axi_mst_arbiter #(
    parameter int NUM_MST = 2,
    parameter int ID_W    = 4,
    parameter int DATA_W  = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NUM_MST-1:0]         m_rreq_valid,
    output logic [NUM_MST-1:0]         m_rreq_ready,
    input  logic [NUM_MST*32-1:0]      m_rreq_addr,
    input  logic [NUM_MST*8-1:0]       m_rreq_len,
    input  logic [NUM_MST*3-1:0]       m_rreq_size,
    output logic [NUM_MST-1:0]         m_rresp_valid,
    output logic [DATA_W-1:0]          m_rresp_data,
    output logic                       m_rresp_last,
    output logic                       m_rresp_err,
    input  logic [NUM_MST-1:0]         m_wreq_valid,
    output logic [NUM_MST-1:0]         m_wreq_ready,
    input  logic [NUM_MST*32-1:0]      m_wreq_addr,
    input  logic [NUM_MST*8-1:0]       m_wreq_len,
    input  logic [NUM_MST*3-1:0]       m_wreq_size,
    input  logic [NUM_MST-1:0]         m_wdata_valid,
    output logic [NUM_MST-1:0]         m_wdata_ready,
    input  logic [NUM_MST*DATA_W-1:0]  m_wdata,
    input  logic [NUM_MST*DATA_W/8-1:0] m_wstrb,
    output logic [NUM_MST-1:0]         m_wresp_valid,
    output logic                       m_wresp_err,
    output logic [ID_W-1:0]            arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic [1:0]                 arlock,
    output logic [3:0]                 arcache,
    output logic [2:0]                 arprot,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [ID_W-1:0]            rid,
    input  logic [DATA_W-1:0]          rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready,
    output logic [ID_W-1:0]            awid,
    output logic [31:0]                awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic [1:0]                 awlock,
    output logic [3:0]                 awcache,
    output logic [2:0]                 awprot,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [ID_W-1:0]            wid,
    output logic [DATA_W-1:0]          wdata,
    output logic [DATA_W/8-1:0]        wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic [ID_W-1:0]            bid,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready
);

    localparam int IDX_W = $clog2(NUM_MST);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_MST - 1) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [NUM_MST-1:0] oneHot(input logic [IDX_W-1:0] idx);
        logic [NUM_MST-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Returns {found, index}; scanning downward lets the closest port after start win.
    function automatic logic [IDX_W:0] pickGrant(input logic [NUM_MST-1:0] req,
                                                 input logic [IDX_W-1:0] start);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] sel;
        int               idx;
        res = '0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NUM_MST) idx = idx - NUM_MST;
            sel = IDX_W'(idx);
            if (req[sel]) res = {1'b1, sel};
        end
        return res;
    endfunction

    logic [1:0]       rdState_q, rdState_d;
    logic [IDX_W-1:0] rrRd_q, rrRd_d, curRd_q, curRd_d, grantRd;
    logic             grantRdVld;
    logic [31:0]      arAddr_q, arAddr_d;
    logic [7:0]       arLen_q, arLen_d;
    logic [2:0]       arSize_q, arSize_d;

    always_comb begin
        rdState_d    = rdState_q;
        rrRd_d       = rrRd_q;
        curRd_d      = curRd_q;
        arAddr_d     = arAddr_q;
        arLen_d      = arLen_q;
        arSize_d     = arSize_q;
        m_rreq_ready = '0;
        {grantRdVld, grantRd} = pickGrant(m_rreq_valid, rrRd_q);
        case (rdState_q)
            R_IDLE: if (grantRdVld) begin
                m_rreq_ready = oneHot(grantRd);
                curRd_d      = grantRd;
                arAddr_d     = m_rreq_addr[int'(grantRd)*32 +: 32];
                arLen_d      = m_rreq_len[int'(grantRd)*8 +: 8];
                arSize_d     = m_rreq_size[int'(grantRd)*3 +: 3];
                rdState_d    = R_ADDR;
            end
            R_ADDR: if (arready) rdState_d = R_DATA;
            R_DATA: if (rvalid && rlast) begin
                rdState_d = R_IDLE;
                rrRd_d    = nextIdx(curRd_q);
            end
            default: rdState_d = R_IDLE;
        endcase
        if (!aresetn) m_rreq_ready = '0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdState_q <= R_IDLE;
            rrRd_q    <= '0;
            curRd_q   <= '0;
            arAddr_q  <= '0;
            arLen_q   <= '0;
            arSize_q  <= '0;
        end else begin
            rdState_q <= rdState_d;
            rrRd_q    <= rrRd_d;
            curRd_q   <= curRd_d;
            arAddr_q  <= arAddr_d;
            arLen_q   <= arLen_d;
            arSize_q  <= arSize_d;
        end
    end

    assign arvalid       = (rdState_q == R_ADDR);
    assign arid          = ID_W'(curRd_q);
    assign araddr        = arAddr_q;
    assign arlen         = arLen_q;
    assign arsize        = arSize_q;
    assign arburst       = 2'b01;
    assign arlock        = 2'b00;
    assign arcache       = 4'b0000;
    assign arprot        = 3'b000;
    assign rready        = (rdState_q == R_DATA);
    assign m_rresp_valid = (rready && rvalid) ? oneHot(curRd_q) : '0;
    assign m_rresp_data  = rdata;
    assign m_rresp_last  = rlast;
    assign m_rresp_err   = rresp[1];

`ifdef AXI_ARB_WRITE_EN
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    logic [1:0]       wrState_q, wrState_d;
    logic [IDX_W-1:0] rrWr_q, rrWr_d, curWr_q, curWr_d, grantWr;
    logic             grantWrVld;
    logic [31:0]      awAddr_q, awAddr_d;
    logic [7:0]       awLen_q, awLen_d;
    logic [2:0]       awSize_q, awSize_d;
    logic [7:0]       wCnt_q, wCnt_d;

    // wCnt stops at the latched len, so len = 255 ends exactly on beat 256.
    always_comb begin
        wrState_d    = wrState_q;
        rrWr_d       = rrWr_q;
        curWr_d      = curWr_q;
        awAddr_d     = awAddr_q;
        awLen_d      = awLen_q;
        awSize_d     = awSize_q;
        wCnt_d       = wCnt_q;
        m_wreq_ready = '0;
        {grantWrVld, grantWr} = pickGrant(m_wreq_valid, rrWr_q);
        case (wrState_q)
            W_IDLE: if (grantWrVld) begin
                m_wreq_ready = oneHot(grantWr);
                curWr_d      = grantWr;
                awAddr_d     = m_wreq_addr[int'(grantWr)*32 +: 32];
                awLen_d      = m_wreq_len[int'(grantWr)*8 +: 8];
                awSize_d     = m_wreq_size[int'(grantWr)*3 +: 3];
                wrState_d    = W_ADDR;
            end
            W_ADDR: if (awready) begin
                wCnt_d    = '0;
                wrState_d = W_DATA;
            end
            W_DATA: if (wvalid && wready) begin
                wCnt_d = wCnt_q + 8'd1;
                if (wlast) wrState_d = W_RESP;
            end
            W_RESP: if (bvalid) begin
                wrState_d = W_IDLE;
                rrWr_d    = nextIdx(curWr_q);
            end
            default: wrState_d = W_IDLE;
        endcase
        if (!aresetn) m_wreq_ready = '0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wrState_q <= W_IDLE;
            rrWr_q    <= '0;
            curWr_q   <= '0;
            awAddr_q  <= '0;
            awLen_q   <= '0;
            awSize_q  <= '0;
            wCnt_q    <= '0;
        end else begin
            wrState_q <= wrState_d;
            rrWr_q    <= rrWr_d;
            curWr_q   <= curWr_d;
            awAddr_q  <= awAddr_d;
            awLen_q   <= awLen_d;
            awSize_q  <= awSize_d;
            wCnt_q    <= wCnt_d;
        end
    end

    assign awvalid       = (wrState_q == W_ADDR);
    assign awid          = ID_W'(curWr_q);
    assign awaddr        = awAddr_q;
    assign awlen         = awLen_q;
    assign awsize        = awSize_q;
    assign awburst       = 2'b01;
    assign awlock        = 2'b00;
    assign awcache       = 4'b0000;
    assign awprot        = 3'b000;
    assign wid           = ID_W'(curWr_q);
    assign wvalid        = (wrState_q == W_DATA) && m_wdata_valid[curWr_q];
    assign wdata         = m_wdata[int'(curWr_q)*DATA_W +: DATA_W];
    assign wstrb         = m_wstrb[int'(curWr_q)*(DATA_W/8) +: DATA_W/8];
    assign wlast         = (wrState_q == W_DATA) && (wCnt_q == awLen_q);
    assign m_wdata_ready = ((wrState_q == W_DATA) && wready) ? oneHot(curWr_q) : '0;
    assign bready        = (wrState_q == W_RESP);
    assign m_wresp_valid = (bready && bvalid) ? oneHot(curWr_q) : '0;
    assign m_wresp_err   = bresp[1];

    logic unusedSink;
    assign unusedSink = ^{rid, rresp[0], bid, bresp[0]};
`else
    assign awvalid       = 1'b0;
    assign awid          = '0;
    assign awaddr        = '0;
    assign awlen         = '0;
    assign awsize        = '0;
    assign awburst       = '0;
    assign awlock        = '0;
    assign awcache       = '0;
    assign awprot        = '0;
    assign wid           = '0;
    assign wvalid        = 1'b0;
    assign wdata         = '0;
    assign wstrb         = '0;
    assign wlast         = 1'b0;
    assign m_wreq_ready  = '0;
    assign m_wdata_ready = '0;
    assign bready        = 1'b0;
    assign m_wresp_valid = '0;
    assign m_wresp_err   = 1'b0;

    logic unusedSink;
    assign unusedSink = ^{rid, rresp[0], bid, bresp, bvalid, awready, wready,
                          m_wreq_valid, m_wreq_addr, m_wreq_len, m_wreq_size,
                          m_wdata_valid, m_wdata, m_wstrb};
`endif

endmodule

// File: tb/tb_axi_mst_arbiter.sv
// Directed bench for axi_mst_arbiter: read beats are checked against a scoreboard queue
// filled when each request is driven; write tests build only with AXI_ARB_WRITE_EN.
module tb_axi_mst_arbiter;

    localparam int NUM_MST = 2;
    localparam int ID_W    = 4;
    localparam int DATA_W  = 32;

    logic                        aclk = 1'b0;
    logic                        aresetn;
    logic [NUM_MST-1:0]          m_rreq_valid, m_rreq_ready;
    logic [NUM_MST*32-1:0]       m_rreq_addr;
    logic [NUM_MST*8-1:0]        m_rreq_len;
    logic [NUM_MST*3-1:0]        m_rreq_size;
    logic [NUM_MST-1:0]          m_rresp_valid;
    logic [DATA_W-1:0]           m_rresp_data;
    logic                        m_rresp_last, m_rresp_err;
    logic [NUM_MST-1:0]          m_wreq_valid, m_wreq_ready;
    logic [NUM_MST*32-1:0]       m_wreq_addr;
    logic [NUM_MST*8-1:0]        m_wreq_len;
    logic [NUM_MST*3-1:0]        m_wreq_size;
    logic [NUM_MST-1:0]          m_wdata_valid, m_wdata_ready;
    logic [NUM_MST*DATA_W-1:0]   m_wdata;
    logic [NUM_MST*DATA_W/8-1:0] m_wstrb;
    logic [NUM_MST-1:0]          m_wresp_valid;
    logic                        m_wresp_err;
    logic [ID_W-1:0]             arid, rid, awid, wid, bid;
    logic [31:0]                 araddr, awaddr;
    logic [7:0]                  arlen, awlen;
    logic [2:0]                  arsize, awsize, arprot, awprot;
    logic [1:0]                  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]                  arcache, awcache;
    logic                        arvalid, arready, rlast, rvalid, rready;
    logic                        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DATA_W-1:0]           rdata, wdata;
    logic [DATA_W/8-1:0]         wstrb;

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t rdQueue[$];
    int    compCount = 0;
    int    errCount  = 0;
    int    expRr     = 0;
    int    beatCount[NUM_MST];

    axi_mst_arbiter #(.NUM_MST(NUM_MST), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_rreq_valid(m_rreq_valid), .m_rreq_ready(m_rreq_ready), .m_rreq_addr(m_rreq_addr),
        .m_rreq_len(m_rreq_len), .m_rreq_size(m_rreq_size), .m_rresp_valid(m_rresp_valid),
        .m_rresp_data(m_rresp_data), .m_rresp_last(m_rresp_last), .m_rresp_err(m_rresp_err),
        .m_wreq_valid(m_wreq_valid), .m_wreq_ready(m_wreq_ready), .m_wreq_addr(m_wreq_addr),
        .m_wreq_len(m_wreq_len), .m_wreq_size(m_wreq_size), .m_wdata_valid(m_wdata_valid),
        .m_wdata_ready(m_wdata_ready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wresp_valid(m_wresp_valid), .m_wresp_err(m_wresp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge aclk);
        #1;
    endtask

    task automatic clearInputs();
        m_rreq_valid = '0; m_rreq_addr = '0; m_rreq_len = '0; m_rreq_size = '0;
        m_wreq_valid = '0; m_wreq_addr = '0; m_wreq_len = '0; m_wreq_size = '0;
        m_wdata_valid = '0; m_wdata = '0; m_wstrb = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    endtask

    task automatic applyStimulus(input int p, input logic [31:0] addr, input logic [7:0] len);
        m_rreq_addr[32*p +: 32] = addr;
        m_rreq_len[8*p +: 8]    = len;
        m_rreq_size[3*p +: 3]   = 3'd2;
        m_rreq_valid[1'(p)]     = 1'b1;
    endtask

    function automatic int modelGrant(input logic [NUM_MST-1:0] req, input int rr);
        for (int k = 0; k < NUM_MST; k++)
            if (req[1'((rr + k) % NUM_MST)]) return (rr + k) % NUM_MST;
        return 0;
    endfunction

    // One complete read transaction; the slave answers with rdata = captured araddr + 4*beat.
    task automatic runRead(input int arWait, input bit keep, input string tag);
        int          g, len;
        logic [31:0] a, slaveAddr;
        beat_t       e;
        g   = modelGrant(m_rreq_valid, expRr);
        a   = m_rreq_addr[32*g +: 32];
        len = int'(m_rreq_len[8*g +: 8]);
        for (int b = 0; b <= len; b++) begin
            e.port = 2'(g);
            e.data = a + 32'(4 * b);
            e.last = (b == len);
            rdQueue.push_back(e);
        end
        #1;
        checkOutput({tag, " rreq_ready"}, 64'(m_rreq_ready), 64'(2'b01 << g));
        stepClock();
        if (!keep) m_rreq_valid[1'(g)] = 1'b0;
        arready = (arWait == 0);
        #1;
        checkOutput({tag, " arvalid"}, 64'(arvalid), 64'(1));
        checkOutput({tag, " arid"}, 64'(arid), 64'(g));
        checkOutput({tag, " araddr"}, 64'(araddr), 64'(a));
        checkOutput({tag, " arlen"}, 64'(arlen), 64'(len));
        checkOutput({tag, " arburst"}, 64'(arburst), 64'(2'b01));
        for (int w = 0; w < arWait; w++) begin
            stepClock();
            arready = (w == arWait - 1);
            #1;
            checkOutput({tag, " stall arvalid"}, 64'(arvalid), 64'(1));
            checkOutput({tag, " stall araddr"}, 64'(araddr), 64'(a));
            checkOutput({tag, " stall rreq_ready"}, 64'(m_rreq_ready), 64'(0));
        end
        slaveAddr = araddr;
        stepClock();
        arready = 1'b0;
        for (int b = 0; b <= len; b++) begin
            rvalid = 1'b1;
            rdata  = slaveAddr + 32'(4 * b);
            rlast  = (b == len);
            rresp  = 2'b00;
            #1;
            checkOutput({tag, " rready"}, 64'(rready), 64'(1));
            checkOutput({tag, " q_nonempty"}, 64'(rdQueue.size() != 0), 64'(1));
            if (rdQueue.size() != 0) begin
                e = rdQueue.pop_front();
                checkOutput({tag, " rresp_valid"}, 64'(m_rresp_valid), 64'(2'b01 << e.port));
                checkOutput({tag, " rresp_data"}, 64'(m_rresp_data), 64'(e.data));
                checkOutput({tag, " rresp_last"}, 64'(m_rresp_last), 64'(e.last));
            end
            if (m_rresp_valid[1'(g)]) beatCount[g]++;
            stepClock();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        expRr  = (g + 1) % NUM_MST;
    endtask

`ifdef AXI_ARB_WRITE_EN
    task automatic runWrite(input int p, input logic [31:0] addr, input logic [7:0] len,
                            input bit toggle, input logic [1:0] resp, input string tag);
        int beat = 0;
        int cyc = 0;
        int lastSeen = 0;
        m_wreq_addr[32*p +: 32] = addr;
        m_wreq_len[8*p +: 8]    = len;
        m_wreq_size[3*p +: 3]   = 3'd2;
        m_wreq_valid[1'(p)]     = 1'b1;
        #1;
        checkOutput({tag, " wreq_ready"}, 64'(m_wreq_ready), 64'(2'b01 << p));
        stepClock();
        m_wreq_valid[1'(p)] = 1'b0;
        awready = 1'b1;
        #1;
        checkOutput({tag, " awvalid"}, 64'(awvalid), 64'(1));
        checkOutput({tag, " awid"}, 64'(awid), 64'(p));
        checkOutput({tag, " awaddr"}, 64'(awaddr), 64'(addr));
        checkOutput({tag, " awlen"}, 64'(awlen), 64'(len));
        stepClock();
        awready = 1'b0;
        while (beat <= int'(len) && cyc < 2 * (int'(len) + 1) + 8) begin
            m_wdata_valid[1'(p)]       = 1'b1;
            m_wdata[32*p +: 32]        = addr + 32'(beat);
            m_wstrb[4*p +: 4]          = 4'hf;
            wready = toggle ? 1'(cyc % 2) : 1'b1;
            #1;
            checkOutput({tag, " wvalid"}, 64'(wvalid), 64'(1));
            checkOutput({tag, " wid"}, 64'(wid), 64'(p));
            checkOutput({tag, " wdata"}, 64'(wdata), 64'(addr + 32'(beat)));
            checkOutput({tag, " wlast"}, 64'(wlast), 64'(beat == int'(len)));
            checkOutput({tag, " wdata_ready"}, 64'(m_wdata_ready), 64'(wready ? (2'b01 << p) : 2'b00));
            if (wready) begin
                if (wlast) lastSeen++;
                beat++;
            end
            cyc++;
            stepClock();
        end
        m_wdata_valid = '0;
        wready = 1'b0;
        checkOutput({tag, " beats"}, 64'(beat), 64'(int'(len) + 1));
        checkOutput({tag, " wlast_count"}, 64'(lastSeen), 64'(1));
        #1;
        checkOutput({tag, " bready"}, 64'(bready), 64'(1));
        checkOutput({tag, " wresp_idle"}, 64'(m_wresp_valid), 64'(0));
        bvalid = 1'b1;
        bresp  = resp;
        #1;
        checkOutput({tag, " wresp_valid"}, 64'(m_wresp_valid), 64'(2'b01 << p));
        checkOutput({tag, " wresp_err"}, 64'(m_wresp_err), 64'(resp[1]));
        stepClock();
        bvalid = 1'b0;
        bresp  = 2'b00;
        #1;
        checkOutput({tag, " wresp_pulse_end"}, 64'(m_wresp_valid), 64'(0));
        checkOutput({tag, " bready_end"}, 64'(bready), 64'(0));
    endtask
`endif

    initial begin
        clearInputs();
        aresetn = 1'b1;
        beatCount = '{0, 0};
        $display("[TB] start");

        // Reset: outputs held low even with requests pending
        #2 aresetn = 1'b0;
        m_rreq_valid = 2'b11;
        m_wreq_valid = 2'b11;
        #1;
        checkOutput("rst rreq_ready", 64'(m_rreq_ready), 64'(0));
        checkOutput("rst wreq_ready", 64'(m_wreq_ready), 64'(0));
        checkOutput("rst arvalid", 64'(arvalid), 64'(0));
        checkOutput("rst rready", 64'(rready), 64'(0));
        checkOutput("rst arid", 64'(arid), 64'(0));
        checkOutput("rst araddr", 64'(araddr), 64'(0));
        checkOutput("rst rresp_valid", 64'(m_rresp_valid), 64'(0));
        checkOutput("rst awvalid", 64'(awvalid), 64'(0));
        checkOutput("rst bready", 64'(bready), 64'(0));
        m_rreq_valid = '0;
        m_wreq_valid = '0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        stepClock();

        // Single read on port 1
        applyStimulus(1, 32'h1c00_0000, 8'd0);
        runRead(0, 1'b0, "single");

        // Both ports request continuously: grants alternate, 16 beats each
        beatCount = '{0, 0};
        applyStimulus(0, 32'h8000_0000, 8'd3);
        applyStimulus(1, 32'h9000_0100, 8'd3);
        for (int i = 0; i < 8; i++) runRead(0, 1'b1, "rr");
        m_rreq_valid = '0;
        checkOutput("rr beats port0", 64'(beatCount[0]), 64'(16));
        checkOutput("rr beats port1", 64'(beatCount[1]), 64'(16));

        // arready stalled for 5 cycles with the other port waiting
        applyStimulus(0, 32'h0000_4000, 8'd1);
        applyStimulus(1, 32'h0000_5000, 8'd1);
        runRead(5, 1'b0, "stall");
        runRead(0, 1'b0, "after_stall");

        // Leave the pointer at port 1, then abandon a burst with reset during beat 2
        applyStimulus(0, 32'h0000_6000, 8'd0);
        runRead(0, 1'b0, "prep");
        applyStimulus(1, 32'h0000_7000, 8'd3);
        #1;
        checkOutput("abort rreq_ready", 64'(m_rreq_ready), 64'(2'b10));
        stepClock();
        m_rreq_valid = '0;
        arready = 1'b1;
        #1;
        checkOutput("abort arvalid", 64'(arvalid), 64'(1));
        stepClock();
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h0000_7000;
        #1;
        checkOutput("abort beat1", 64'(m_rresp_valid), 64'(2'b10));
        stepClock();
        rdata = 32'h0000_7004;
        #1;
        checkOutput("abort beat2", 64'(m_rresp_valid), 64'(2'b10));
        aresetn = 1'b0;
        #1;
        checkOutput("abort rready", 64'(rready), 64'(0));
        checkOutput("abort arvalid_rst", 64'(arvalid), 64'(0));
        checkOutput("abort rresp_valid", 64'(m_rresp_valid), 64'(0));
        checkOutput("abort araddr_rst", 64'(araddr), 64'(0));
        rvalid = 1'b0;
        rdQueue.delete();
        stepClock();
        aresetn = 1'b1;
        expRr = 0;
        stepClock();
        applyStimulus(0, 32'h0000_8000, 8'd0);
        applyStimulus(1, 32'h0000_9000, 8'd0);
        runRead(0, 1'b0, "post_rst_a");
        runRead(0, 1'b0, "post_rst_b");

`ifdef AXI_ARB_WRITE_EN
        // Long write with toggling wready and a SLVERR response
        runWrite(0, 32'h2000_0000, 8'd255, 1'b1, 2'b10, "wr255");

        // Concurrent read on port 0 and write on port 1
        applyStimulus(0, 32'h0000_a000, 8'd0);
        m_wreq_addr[63:32] = 32'h0000_b000;
        m_wreq_len[15:8] = 8'd0;
        m_wreq_valid = 2'b10;
        #1;
        checkOutput("conc rreq_ready", 64'(m_rreq_ready), 64'(2'b01));
        checkOutput("conc wreq_ready", 64'(m_wreq_ready), 64'(2'b10));
        stepClock();
        m_rreq_valid = '0;
        m_wreq_valid = '0;
        arready = 1'b1;
        awready = 1'b1;
        #1;
        checkOutput("conc arid", 64'(arid), 64'(0));
        checkOutput("conc awid", 64'(awid), 64'(1));
        checkOutput("conc awaddr", 64'(awaddr), 64'(32'h0000_b000));
        stepClock();
        arready = 1'b0;
        awready = 1'b0;
        rvalid = 1'b1;
        rlast = 1'b1;
        rdata = 32'h0000_a000;
        m_wdata_valid = 2'b10;
        m_wdata[63:32] = 32'hcafe_f00d;
        wready = 1'b1;
        #1;
        checkOutput("conc rresp_valid", 64'(m_rresp_valid), 64'(2'b01));
        checkOutput("conc wvalid", 64'(wvalid), 64'(1));
        checkOutput("conc wdata", 64'(wdata), 64'(32'hcafe_f00d));
        checkOutput("conc wlast", 64'(wlast), 64'(1));
        stepClock();
        rvalid = 1'b0;
        rlast = 1'b0;
        m_wdata_valid = '0;
        wready = 1'b0;
        bvalid = 1'b1;
        bresp = 2'b00;
        #1;
        checkOutput("conc wresp_valid", 64'(m_wresp_valid), 64'(2'b10));
        checkOutput("conc wresp_err", 64'(m_wresp_err), 64'(0));
        checkOutput("conc rresp_done", 64'(m_rresp_valid), 64'(0));
        stepClock();
        bvalid = 1'b0;
        expRr = 1;
`else
        // Write path absent: every write-side output stays low
        m_wreq_valid = 2'b11;
        m_wdata_valid = 2'b11;
        wready = 1'b1;
        awready = 1'b1;
        bvalid = 1'b1;
        bresp = 2'b10;
        #1;
        checkOutput("nowr wreq_ready", 64'(m_wreq_ready), 64'(0));
        checkOutput("nowr awvalid", 64'(awvalid), 64'(0));
        checkOutput("nowr wvalid", 64'(wvalid), 64'(0));
        checkOutput("nowr wlast", 64'(wlast), 64'(0));
        checkOutput("nowr bready", 64'(bready), 64'(0));
        checkOutput("nowr wresp_valid", 64'(m_wresp_valid), 64'(0));
        checkOutput("nowr wresp_err", 64'(m_wresp_err), 64'(0));
        checkOutput("nowr wdata_ready", 64'(m_wdata_ready), 64'(0));
        stepClock();
        checkOutput("nowr awvalid_later", 64'(awvalid), 64'(0));
        checkOutput("nowr awaddr", 64'(awaddr), 64'(0));
        clearInputs();
`endif

        // Read path still arbitrates normally afterwards
        applyStimulus(1, 32'h0000_c000, 8'd1);
        runRead(0, 1'b0, "final");
        checkOutput("final queue_empty", 64'(rdQueue.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
